// File: rtl/reg_file_mp.sv
// Multi-port register file: two registered read ports, one handshaked write port, and a
// post-reset init sequencer. Define REGFILE_BYPASS_EN to enable write-to-read bypass.
module reg_file_mp #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              rd_en0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [WIDTH-1:0]  rd_data0,
    output logic              rd_valid0,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    output logic              rd_valid1,
    output logic              init_busy,
    output logic              addr_err
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rd_data0_q, rd_data0_d;
    logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
    logic              rd_valid0_q, rd_valid0_d;
    logic              rd_valid1_q, rd_valid1_d;
    logic              addr_err_q, addr_err_d;

    logic              wr_oor, rd0_oor, rd1_oor;
    logic              wr_commit, byp0, byp1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    // Priority: out-of-range and zero register force 0, then bypass, then stored value.
    function automatic logic [WIDTH-1:0] rd_mux(input logic oor, input logic is_zero,
                                                input logic byp, input logic [WIDTH-1:0] wdata,
                                                input logic [WIDTH-1:0] stored);
        if (oor || is_zero) begin
            rd_mux = '0;
        end else if (byp) begin
            rd_mux = wdata;
        end else begin
            rd_mux = stored;
        end
    endfunction

    assign wr_oor  = 32'(wr_addr) >= DEPTH;
    assign rd0_oor = 32'(rd_addr0) >= DEPTH;
    assign rd1_oor = 32'(rd_addr1) >= DEPTH;

    // Only accepted, in-range, non-zero-register writes actually land in the array.
    assign wr_commit = (state_q == StRun) && wr_en && !wr_oor && !(ZERO_REG && wr_addr == '0);
    assign byp0      = BypassEn && wr_commit && (wr_addr == rd_addr0);
    assign byp1      = BypassEn && wr_commit && (wr_addr == rd_addr1);

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_data;
        rd_data0_d  = rd_data0_q;
        rd_data1_d  = rd_data1_q;
        rd_valid0_d = 1'b0;
        rd_valid1_d = 1'b0;
        addr_err_d  = 1'b0;

        case (state_q)
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = WIDTH'(init_ptr_q);
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                if (init_ptr_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we     = wr_commit;
                addr_err_d = (wr_en && wr_oor) || (rd_en0 && rd0_oor) || (rd_en1 && rd1_oor);
                if (rd_en0) begin
                    rd_valid0_d = 1'b1;
                    rd_data0_d  = rd_mux(rd0_oor, ZERO_REG && rd_addr0 == '0, byp0, wr_data,
                                         mem_q[rd_addr0]);
                end
                if (rd_en1) begin
                    rd_valid1_d = 1'b1;
                    rd_data1_d  = rd_mux(rd1_oor, ZERO_REG && rd_addr1 == '0, byp1, wr_data,
                                         mem_q[rd_addr1]);
                end
            end
            default: state_d = StInit;
        endcase

        // Reset wins over everything, including init and user writes.
        if (!reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StInit;
            init_ptr_q  <= '0;
            rd_data0_q  <= '0;
            rd_data1_q  <= '0;
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            rd_data0_q  <= rd_data0_d;
            rd_data1_q  <= rd_data1_d;
            rd_valid0_q <= rd_valid0_d;
            rd_valid1_q <= rd_valid1_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Array is never cleared; the init sequencer is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign wr_ready  = (state_q == StRun);
    assign init_busy = (state_q == StInit);
    assign rd_data0  = rd_data0_q;
    assign rd_data1  = rd_data1_q;
    assign rd_valid0 = rd_valid0_q;
    assign rd_valid1 = rd_valid1_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations (8 deep, 6 deep, 8 deep with zero register)
// share one stimulus stream and are each checked against an array-based reference model.
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en0, rd_en1;
    logic [2:0] rd_addr0, rd_addr1;

    logic [2:0][7:0] rd_data0_w, rd_data1_w;
    logic [2:0]      rd_valid0_w, rd_valid1_w, init_busy_w, addr_err_w, wr_ready_w;

    always #5 clk = ~clk;

    reg_file_mp #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1'b0)) u_d8 (
        .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready_w[0]), .rd_en0(rd_en0), .rd_addr0(rd_addr0),
        .rd_data0(rd_data0_w[0]), .rd_valid0(rd_valid0_w[0]), .rd_en1(rd_en1),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1_w[0]), .rd_valid1(rd_valid1_w[0]),
        .init_busy(init_busy_w[0]), .addr_err(addr_err_w[0])
    );

    reg_file_mp #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1'b0)) u_d6 (
        .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready_w[1]), .rd_en0(rd_en0), .rd_addr0(rd_addr0),
        .rd_data0(rd_data0_w[1]), .rd_valid0(rd_valid0_w[1]), .rd_en1(rd_en1),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1_w[1]), .rd_valid1(rd_valid1_w[1]),
        .init_busy(init_busy_w[1]), .addr_err(addr_err_w[1])
    );

    reg_file_mp #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1'b1)) u_z8 (
        .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready_w[2]), .rd_en0(rd_en0), .rd_addr0(rd_addr0),
        .rd_data0(rd_data0_w[2]), .rd_valid0(rd_valid0_w[2]), .rd_en1(rd_en1),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1_w[2]), .rd_valid1(rd_valid1_w[2]),
        .init_busy(init_busy_w[2]), .addr_err(addr_err_w[2])
    );

    // Reference model state per configuration.
    int         m_depth [3] = '{8, 6, 8};
    bit         m_zr    [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] m_mem   [3][8];
    int         m_left  [3];
    int         m_ptr   [3];
    logic [7:0] e_d0 [3], e_d1 [3];
    logic       e_v0 [3], e_v1 [3], e_err [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int i, input int a, input bit wok);
        if (a >= m_depth[i]) return 8'h00;
        if (m_zr[i] && a == 0) return 8'h00;
        if (Bypass && wok && int'(wr_addr) == a) return wr_data;
        return m_mem[i][a];
    endfunction

    task automatic m_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_left[i] = m_depth[i];
                m_ptr[i]  = 0;
                e_d0[i]   = 8'h00;
                e_d1[i]   = 8'h00;
                e_v0[i]   = 1'b0;
                e_v1[i]   = 1'b0;
                e_err[i]  = 1'b0;
            end else if (m_left[i] > 0) begin
                m_mem[i][m_ptr[i]] = 8'(m_ptr[i]);
                m_ptr[i]++;
                m_left[i]--;
                e_v0[i]  = 1'b0;
                e_v1[i]  = 1'b0;
                e_err[i] = 1'b0;
            end else begin
                bit wok;
                wok = wr_en && int'(wr_addr) < m_depth[i] && !(m_zr[i] && wr_addr == 3'd0);
                e_err[i] = (wr_en && int'(wr_addr) >= m_depth[i]) ||
                           (rd_en0 && int'(rd_addr0) >= m_depth[i]) ||
                           (rd_en1 && int'(rd_addr1) >= m_depth[i]);
                e_v0[i] = rd_en0;
                e_v1[i] = rd_en1;
                if (rd_en0) e_d0[i] = m_read(i, int'(rd_addr0), wok);
                if (rd_en1) e_d1[i] = m_read(i, int'(rd_addr1), wok);
                if (wok) m_mem[i][wr_addr] = wr_data;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.init_busy", i), 32'(init_busy_w[i]), 32'(m_left[i] > 0));
            check($sformatf("u%0d.wr_ready", i), 32'(wr_ready_w[i]),
                  32'(rst_n && m_left[i] == 0));
            check($sformatf("u%0d.rd_valid0", i), 32'(rd_valid0_w[i]), 32'(e_v0[i]));
            check($sformatf("u%0d.rd_valid1", i), 32'(rd_valid1_w[i]), 32'(e_v1[i]));
            check($sformatf("u%0d.rd_data0", i), 32'(rd_data0_w[i]), 32'(e_d0[i]));
            check($sformatf("u%0d.rd_data1", i), 32'(rd_data1_w[i]), 32'(e_d1[i]));
            check($sformatf("u%0d.addr_err", i), 32'(addr_err_w[i]), 32'(e_err[i]));
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic r0, input logic [2:0] a0,
                         input logic r1, input logic [2:0] a1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en0   = r0;
        rd_addr0 = a0;
        rd_en1   = r1;
        rd_addr1 = a1;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom), 3'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        repeat (2) cycle();

        // Writes and reads during init must be refused/ignored.
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 8'hAA, 1'b1, 3'd2, 1'b1, 3'd4);
        repeat (6) cycle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        repeat (2) cycle();

        // Read back the init pattern on both ports, in opposite orders.
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1, 3'(7 - a));
            cycle();
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();

        // Same-cycle write/read of address 5, then read it again.
        drive(1'b1, 3'd5, 8'h5A, 1'b1, 3'd5, 1'b0, 3'd0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd5);
        cycle();

        // Out-of-range accesses for the 6-deep file.
        drive(1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd7);
        cycle();

        // Zero-register write attempt, then read address 0 on both ports.
        drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();

        for (int n = 0; n < 300; n++) begin
            drive_random();
            cycle();
        end

        // Reset in the middle of RUN with live read traffic, then again at init cycle 4.
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd6);
        cycle();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (8) cycle();
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1, 3'(a));
            cycle();
        end

        for (int n = 0; n < 100; n++) begin
            drive_random();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
